// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state type, data width and parameter defaults for data_mem_responder.
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    localparam int XLEN             = 32;
    localparam int DEPTH_WORDS_DFLT = 1024;
    localparam int LATENCY_DFLT     = 2;
    localparam int CNT_W            = 4;
endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: one byte lane of storage, DEPTH entries, synchronous write, registered read.
// Ports: clk, rst_b (active-high, clears only the read register), we_i (write enable),
//        re_i (access strobe), addr_i (entry index), wdata_i (write byte), rdata_o (read byte).
module dmem_bank #(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o
);
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;
    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end
    // Write-first so a store returns its post-write byte; zero in every cycle that
    // does not follow an access, which keeps the response bus quiet outside RESP.
    always_ff @(posedge clk) begin
        if (rst_b || !re_i) rdata_q <= '0;
        else                rdata_q <= we_i ? wdata_i : mem_q[addr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency byte-lane data memory with a valid/ready request side.
// Ports: clk, rst_b (sync active-high reset), req_valid/req_ready handshake, req_write,
//        req_addr (byte address), req_be (lane enables), req_wdata (lanes, 0 = bits 7:0),
//        resp_valid (one-cycle strobe), resp_rdata (lanes), resp_err.
// Optional: define DMEM_ALIGN_CHECK_EN to flag misaligned accesses with resp_err.
module data_mem_responder #(
    parameter int XLEN        = dmem_pkg::XLEN,
    parameter int DEPTH_WORDS = dmem_pkg::DEPTH_WORDS_DFLT,
    parameter int LATENCY     = dmem_pkg::LATENCY_DFLT
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [XLEN-1:0] req_addr,
    input  logic [3:0]      req_be,
    input  logic [7:0]      req_wdata [0:3],
    output logic            resp_valid,
    output logic [7:0]      resp_rdata [0:3],
    output logic            resp_err
);
    import dmem_pkg::*;
    localparam int AW = $clog2(DEPTH_WORDS);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             write_q;
    logic [AW-1:0]    idx_q;
    logic [1:0]       off_q;
    logic [3:0]       be_q;
    logic [7:0]       wdata_q [0:3];
    logic             resp_valid_q, resp_err_q;
    logic             access, mis, addr_unused;
    // Address bits above the word index are ignored so addresses wrap.
    assign addr_unused = ^{req_addr >> (AW + 2), off_q};
`ifdef DMEM_ALIGN_CHECK_EN
    assign mis = off_q != 2'b00;
`else
    assign mis = 1'b0;
`endif
    // The WAIT-to-RESP edge; masked by reset so an aborted store never commits.
    assign access = !rst_b && state_q == WAIT && cnt_q == '0;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = WAIT;
                cnt_d   = CNT_W'(LATENCY - 1);
            end
            WAIT: if (cnt_q == '0) state_d = RESP;
                  else cnt_d = cnt_q - 1'b1;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= access;
            resp_err_q   <= access && mis;
            if (state_q == IDLE && req_valid) begin
                write_q <= req_write;
                idx_q   <= req_addr[AW+1:2];
                off_q   <= req_addr[1:0];
                be_q    <= req_be;
                wdata_q <= req_wdata;
            end
        end
    end
    for (genvar b = 0; b < 4; b++) begin : g_bank
        dmem_bank #(.DEPTH(DEPTH_WORDS)) u_bank (
            .clk    (clk),
            .rst_b  (rst_b),
            .we_i   (access && !mis && write_q && be_q[b]),
            .re_i   (access && !mis),
            .addr_i (idx_q),
            .wdata_i(wdata_q[b]),
            .rdata_o(resp_rdata[b])
        );
    end
    assign req_ready  = state_q == IDLE;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed checks against a word-array reference model.
module tb_data_mem_responder;
    localparam int LAT = 2;
    localparam int DW  = 1024;
    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic        req_valid, req_ready, req_write, resp_valid, resp_err;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [7:0]  req_wdata [0:3];
    logic [7:0]  resp_rdata [0:3];
    logic [31:0] ref_mem [DW];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.XLEN(32), .DEPTH_WORDS(DW), .LATENCY(LAT)) dut (
        .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rword();
        return {resp_rdata[3], resp_rdata[2], resp_rdata[1], resp_rdata[0]};
    endfunction

    function automatic bit misaligned(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive(input logic v, input logic w, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_be    = be;
        for (int i = 0; i < 4; i++) req_wdata[i] = wd[8*i +: 8];
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!req_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (k == 20) check("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    // Model update: whole-word view, store commits selected lanes unless flagged.
    task automatic model(input logic w, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, output logic [31:0] exp, output bit e);
        int idx;
        idx = int'((a >> 2) % DW);
        e = misaligned(a);
        if (w && !e)
            for (int i = 0; i < 4; i++)
                if (be[i]) ref_mem[idx][8*i +: 8] = wd[8*i +: 8];
        exp = e ? 32'h0 : ref_mem[idx];
    endtask

    task automatic xact(input string tag, input logic w, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd, input bit noise);
        logic [31:0] exp;
        bit e;
        int n = 0;
        model(w, a, be, wd, exp, e);
        wait_ready();
        drive(1'b1, w, a, be, wd);
        @(posedge clk); #1;
        // Requests presented while busy must neither be taken nor disturb the capture.
        drive(noise ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom), $urandom, 4'($urandom), $urandom);
        while (!resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        check({tag, "_lat"}, 32'(n), 32'(LAT));
        check({tag, "_data"}, rword(), exp);
        check({tag, "_err"}, 32'(resp_err), 32'(e));
        @(posedge clk); #1;
        check({tag, "_pulse"}, {resp_valid, rword()[30:0]}, 32'h0);
    endtask

    initial begin
        logic [31:0] a, exp, first_exp;
        bit e, seen;
        int n, g;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", rword(), 32'h0);
        check("rst_err", 32'(resp_err), 32'd0);
        rst_b = 1'b0;

        xact("st_full", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
        xact("ld_full", 1'b0, 32'h10, 4'hF, 32'h0, 1'b0);
        check("ld_full_lit", ref_mem[4], 32'hDEADBEEF);
        xact("st_part", 1'b1, 32'h10, 4'b0101, 32'h11223344, 1'b0);
        xact("ld_part", 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
        check("ld_part_lit", ref_mem[4], 32'hDE22BE44);
        xact("st_wrap", 1'b1, 32'h1000, 4'hF, 32'hA5A5A5A5, 1'b0);
        xact("ld_wrap", 1'b0, 32'h0, 4'hF, 32'h0, 1'b0);
        xact("st_noop", 1'b1, 32'h0, 4'h0, 32'h01234567, 1'b0);
        xact("ld_noop", 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);

        // Reset while the store sits in WAIT: nothing may commit or respond.
        xact("st_prior", 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 1'b0);
        wait_ready();
        drive(1'b1, 1'b1, 32'h20, 4'hF, 32'h12345678);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst_b = 1'b1;
        seen = resp_valid;
        @(posedge clk); #1;
        rst_b = 1'b0;
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        repeat (5) begin
            seen |= resp_valid;
            @(posedge clk); #1;
        end
        check("mid_rst_novalid", 32'(seen), 32'd0);
        xact("ld_prior", 1'b0, 32'h20, 4'hF, 32'h0, 1'b0);

        xact("st_unal", 1'b1, 32'h13, 4'hF, 32'h55AA55AA, 1'b0);
        xact("ld_unal", 1'b0, 32'h10, 4'hF, 32'h0, 1'b0);

        // A request held high through WAIT/RESP is taken at the next IDLE.
        model(1'b0, 32'h10, 4'h0, 32'h0, first_exp, e);
        wait_ready();
        drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 32'h24, 4'hF, 32'h600DF00D);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("held_first", rword(), first_exp);
        model(1'b1, 32'h24, 4'hF, 32'h600DF00D, exp, e);
        g = 0;
        do begin
            @(posedge clk); #1;
            g++;
        end while (!resp_valid && g < 20);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        check("held_second", rword(), exp);
        check("held_spacing", 32'(g >= LAT + 1 && g < 20), 32'd1);
        @(posedge clk); #1;
        xact("held_ld", 1'b0, 32'h24, 4'h0, 32'h0, 1'b0);

        for (int i = 0; i < 64; i++) xact("fill", 1'b1, 32'(i * 4), 4'hF, $urandom, 1'b1);
        for (int i = 0; i < 150; i++) begin
            a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 63)) << 2);
            if ($urandom_range(0, 3) == 0) a |= 32'($urandom_range(1, 3));
            xact("rnd", 1'($urandom), a, 4'($urandom), $urandom, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- XLEN, 32, data and address width.
- DEPTH_WORDS, 1024, storage size in 32-bit words; power of two.
- LATENCY, 2, edges from request acceptance to response; legal range 1..15.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on rising edge.
- rst_b, in, 1, reset; synchronous, active-high.
- req_valid, in, 1, request present.
- req_ready, out, 1, responder can accept a request.
- req_write, in, 1, 1 = store, 0 = load.
- req_addr, in, XLEN, byte address.
- req_be, in, 4, byte-lane write enables; bit i gates lane i.
- req_wdata, in, 8 x [0:3], store byte lanes; lane 0 = bits 7:0 of the word.
- resp_valid, out, 1, one-cycle response strobe.
- resp_rdata, out, 8 x [0:3], load data byte lanes, same lane order.
- resp_err, out, 1, error flag, qualified by resp_valid.

Function
REQ-003 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-004 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on an edge where req_valid && req_ready.
REQ-005 At acceptance the block SHALL capture req_write, req_addr, req_be and req_wdata, load cnt = LATENCY-1 and go to WAIT; later input changes SHALL be ignored.
REQ-006 In WAIT, the FSM SHALL go to RESP when cnt==0 and otherwise decrement cnt.
REQ-007 The memory access SHALL be performed on the WAIT-to-RESP edge.
REQ-008 resp_valid SHALL be high for exactly the single RESP cycle, i.e. LATENCY edges after acceptance, and the FSM SHALL then return to IDLE.
REQ-009 Back-to-back requests SHALL have a minimum spacing of LATENCY+1 cycles; there is no response backpressure.
REQ-010 The word index SHALL be req_addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-011 A store SHALL write only lanes whose req_be bit is 1; req_be==0 SHALL be a legal no-op store.
REQ-012 resp_rdata on a store SHALL be the post-write word; on a load it SHALL be all four lanes, regardless of req_be.
REQ-013 resp_rdata and resp_err SHALL be 0 outside RESP.
REQ-014 req_valid asserted in WAIT or RESP SHALL not be accepted, SHALL have no side effects, and SHALL be accepted in the next IDLE cycle if still asserted.

Reset
REQ-015 While rst_b=1 the block SHALL go to IDLE with cnt=0, req_ready=1, resp_valid=0, resp_rdata=0 and resp_err=0.
REQ-016 Reset during WAIT SHALL abandon the captured request, and its store SHALL NOT commit.
REQ-017 Reset SHALL NOT clear storage contents.

Configuration
REQ-018 With macro DMEM_ALIGN_CHECK_EN defined, a request with req_addr[1:0]!=0 SHALL complete with normal latency and resp_err=1, resp_rdata=0 and no store commit.
REQ-019 Without DMEM_ALIGN_CHECK_EN, req_addr[1:0] SHALL be ignored, resp_err SHALL be tied to 0, and all accesses SHALL be word-aligned.

Structure
REQ-020 Package dmem_pkg SHALL hold the state enum (IDLE, WAIT, RESP), XLEN, and the defaults for DEPTH_WORDS and LATENCY.
REQ-021 Storage SHALL be four instances of sub-module dmem_bank, each one byte wide and DEPTH_WORDS deep with a synchronous write enable; the top level holds the FSM and the capture registers.

Verification
REQ-022 Reset scenario: rst_b=1 for 2 cycles -> req_ready=1, resp_valid=0, resp_rdata=0.
REQ-023 Store/load scenario, LATENCY=2: store 0xDEADBEEF to 0x10 with be=4'hF, then load 0x10 -> each resp_valid occurs exactly 2 edges after its acceptance, and the load returns lanes {EF,BE,AD,DE}.
REQ-024 Partial store scenario: store 0x11223344 to 0x10 with be=4'b0101, then load -> 0xDE22BE44.
REQ-025 Wrap scenario, DEPTH_WORDS=1024: store 0xA5A5A5A5 to 0x1000, then load 0x0 -> 0xA5A5A5A5.
REQ-026 Reset-mid-operation scenario: store 0x12345678 to 0x20, assert rst_b in the WAIT cycle, then load 0x20 -> prior contents returned and no resp_valid for the aborted store.
REQ-027 Alignment scenario, DMEM_ALIGN_CHECK_EN defined: store to 0x13 -> resp_err=1 and memory unchanged; without the macro, the same store writes word 0x10.
